// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and defaults for the hazard/scoreboard unit.
// Optional build macro HAZARD_PERF_CNT_EN is consumed by the interface and top.
package hazard_pkg;

   localparam int unsigned REG_AW_DEFAULT = 5;

   // EX-stage operand source select
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   // Multi-cycle mul/div tracker state
   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

endpackage

// File: rtl/hazard_ctrl_sb_if.sv
// hazard_ctrl_sb_if: pipeline <-> hazard unit signal bundle.
// master = pipeline side, slave = hazard unit.
// With HAZARD_PERF_CNT_EN defined, the performance counter outputs are added.
interface hazard_ctrl_sb_if #(
   parameter int unsigned REG_AW = hazard_pkg::REG_AW_DEFAULT
);
   localparam int unsigned NUM_REGS = 2 ** REG_AW;

   logic [REG_AW-1:0]   rs1_ID;
   logic [REG_AW-1:0]   rs2_ID;
   logic [REG_AW-1:0]   rd_ID;
   logic                use_rs1_ID;
   logic                use_rs2_ID;
   logic                wr_ID;
   logic                md_ID;
   logic [REG_AW-1:0]   rs1_EX;
   logic [REG_AW-1:0]   rs2_EX;
   logic [REG_AW-1:0]   rd_EX;
   logic                load_EX;
   logic                md_issue_EX;
   logic                PCSrc_EX;
   logic [REG_AW-1:0]   rd_MEM;
   logic                RegWrite_MEM;
   logic [REG_AW-1:0]   rd_WB;
   logic                RegWrite_WB;
   logic                dmem_stall_i;
   logic                md_done_i;
   logic                stall_IF;
   logic                stall_ID;
   logic                stall_EX;
   logic                stall_MEM;
   logic                flush_ID;
   logic                flush_EX;
   logic [1:0]          forwardA_EX;
   logic [1:0]          forwardB_EX;
   logic                md_busy_o;
   logic [NUM_REGS-1:0] sb_busy_o;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0]         lu_stall_cnt_o;
   logic [31:0]         sb_stall_cnt_o;
   logic [31:0]         flush_cnt_o;
`endif

   modport master (
      output rs1_ID, rs2_ID, rd_ID, use_rs1_ID, use_rs2_ID, wr_ID, md_ID,
      output rs1_EX, rs2_EX, rd_EX, load_EX, md_issue_EX, PCSrc_EX,
      output rd_MEM, RegWrite_MEM, rd_WB, RegWrite_WB, dmem_stall_i, md_done_i,
      input  stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX,
      input  forwardA_EX, forwardB_EX, md_busy_o, sb_busy_o
`ifdef HAZARD_PERF_CNT_EN
      , input lu_stall_cnt_o, sb_stall_cnt_o, flush_cnt_o
`endif
   );

   modport slave (
      input  rs1_ID, rs2_ID, rd_ID, use_rs1_ID, use_rs2_ID, wr_ID, md_ID,
      input  rs1_EX, rs2_EX, rd_EX, load_EX, md_issue_EX, PCSrc_EX,
      input  rd_MEM, RegWrite_MEM, rd_WB, RegWrite_WB, dmem_stall_i, md_done_i,
      output stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX,
      output forwardA_EX, forwardB_EX, md_busy_o, sb_busy_o
`ifdef HAZARD_PERF_CNT_EN
      , output lu_stall_cnt_o, sb_stall_cnt_o, flush_cnt_o
`endif
   );

endinterface

// File: rtl/md_scoreboard.sv
// md_scoreboard: tracks the single outstanding mul/div op and its pending
// destination register. Completion comes from md_done_i (MD_FIXED_LAT=0) or
// from an internal down-counter loaded with MD_FIXED_LAT at issue.
module md_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW       = REG_AW_DEFAULT,
   parameter int unsigned MD_FIXED_LAT = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     issue_i,     // already qualified by stall/flush
   input  logic [REG_AW-1:0]        issue_rd_i,
   input  logic                     md_done_i,
   output logic                     md_busy_o,
   output logic [(2**REG_AW)-1:0]   sb_busy_o
);
   localparam int unsigned NUM_REGS = 2 ** REG_AW;
   localparam logic [7:0] LAT_LOAD =
      (MD_FIXED_LAT > 255) ? 8'd255 : 8'(MD_FIXED_LAT);
   localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

   md_state_e           state_q;
   logic [7:0]          cnt_q;
   logic [REG_AW-1:0]   md_rd_q;
   logic [NUM_REGS-1:0] busy_q;

   logic                done;
   logic                accept;
   logic [NUM_REGS-1:0] clr_mask;
   logic [NUM_REGS-1:0] set_mask;

   // Completion and issue acceptance; an issue in the completion cycle is legal
   always_comb begin
      done     = 1'b0;
      if (state_q == MD_BUSY) begin
         done = (MD_FIXED_LAT == 0) ? md_done_i : (cnt_q == 8'd1);
      end
      accept   = issue_i && (issue_rd_i != '0) && ((state_q == MD_IDLE) || done);
      clr_mask = done   ? (ONE << md_rd_q)    : '0;
      set_mask = accept ? (ONE << issue_rd_i) : '0;
   end

   // Tracker FSM: state, latency counter, pending rd and busy vector
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MD_IDLE;
         cnt_q   <= 8'd0;
         md_rd_q <= '0;
         busy_q  <= '0;
      end else begin
         // clear before set so a same-rd reissue stays pending
         busy_q <= (busy_q & ~clr_mask) | set_mask;
         unique case (state_q)
            MD_IDLE: begin
               if (accept) begin
                  state_q <= MD_BUSY;
                  md_rd_q <= issue_rd_i;
                  cnt_q   <= LAT_LOAD;
               end
            end
            MD_BUSY: begin
               if (accept) begin
                  md_rd_q <= issue_rd_i;
                  cnt_q   <= LAT_LOAD;
               end else begin
                  if (done) state_q <= MD_IDLE;
                  // counts through data-memory freezes too
                  if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
               end
            end
            default: state_q <= MD_IDLE;
         endcase
      end
   end

   assign md_busy_o = (state_q == MD_BUSY);
   assign sb_busy_o = busy_q;

   // A second issue while the first is still running must be blocked upstream
   a_no_issue_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
      !(issue_i && (issue_rd_i != '0) && (state_q == MD_BUSY) && !done));

endmodule

// File: rtl/hazard_ctrl_sb.sv
// hazard_ctrl_sb: EX forwarding, load-use stall, branch flush, data-memory
// freeze and mul/div scoreboard for the 5-stage pipeline.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_ctrl_sb
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW       = REG_AW_DEFAULT,
   parameter int unsigned MD_FIXED_LAT = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   hazard_ctrl_sb_if.slave  bus
);
   localparam int unsigned NUM_REGS = 2 ** REG_AW;

   logic                lu;
   logic                sbh;
   logic                raw;
   logic                waw;
   logic                strct;
   logic                issue_ok;
   logic                md_busy;
   logic [NUM_REGS-1:0] sb_busy;
   logic                stall_if, stall_id, stall_ex, stall_mem;
   logic                flush_id, flush_ex;

   function automatic fwd_sel_e fwd_sel(input logic [REG_AW-1:0] rs,
                                        input logic [REG_AW-1:0] rd_mem,
                                        input logic              we_mem,
                                        input logic [REG_AW-1:0] rd_wb,
                                        input logic              we_wb);
      if (we_mem && (rd_mem == rs) && (rs != '0)) return FWD_MEM;
      if (we_wb  && (rd_wb  == rs) && (rs != '0)) return FWD_WB;
      return FWD_RF;
   endfunction

   // EX operand forwarding, youngest producer wins
   always_comb begin
      bus.forwardA_EX = fwd_sel(bus.rs1_EX, bus.rd_MEM, bus.RegWrite_MEM,
                                bus.rd_WB, bus.RegWrite_WB);
      bus.forwardB_EX = fwd_sel(bus.rs2_EX, bus.rd_MEM, bus.RegWrite_MEM,
                                bus.rd_WB, bus.RegWrite_WB);
   end

   // Load-use and scoreboard hazard detection for the ID instruction
   always_comb begin
      lu    = bus.load_EX && (bus.rd_EX != '0) &&
              ((bus.use_rs1_ID && (bus.rs1_ID == bus.rd_EX)) ||
               (bus.use_rs2_ID && (bus.rs2_ID == bus.rd_EX)));
      raw   = (sb_busy[bus.rs1_ID] && bus.use_rs1_ID) ||
              (sb_busy[bus.rs2_ID] && bus.use_rs2_ID);
      waw   = bus.wr_ID && sb_busy[bus.rd_ID];
      strct = bus.md_ID && md_busy;
      sbh   = raw || waw || strct;
   end

   // Priority: memory freeze, then branch flush, then hazard bubble
   always_comb begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      stall_ex  = 1'b0;
      stall_mem = 1'b0;
      flush_id  = 1'b0;
      flush_ex  = 1'b0;
      if (bus.dmem_stall_i) begin
         stall_if  = 1'b1;
         stall_id  = 1'b1;
         stall_ex  = 1'b1;
         stall_mem = 1'b1;
      end else if (bus.PCSrc_EX) begin
         flush_id = 1'b1;
         flush_ex = 1'b1;
      end else if (lu || sbh) begin
         stall_if = 1'b1;
         stall_id = 1'b1;
         flush_ex = 1'b1;
      end
   end

   assign bus.stall_IF  = stall_if;
   assign bus.stall_ID  = stall_id;
   assign bus.stall_EX  = stall_ex;
   assign bus.stall_MEM = stall_mem;
   assign bus.flush_ID  = flush_id;
   assign bus.flush_EX  = flush_ex;

   assign issue_ok = bus.md_issue_EX && !stall_ex && !flush_ex;

   md_scoreboard #(
      .REG_AW       (REG_AW),
      .MD_FIXED_LAT (MD_FIXED_LAT)
   ) u_md_scoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .issue_i    (issue_ok),
      .issue_rd_i (bus.rd_EX),
      .md_done_i  (bus.md_done_i),
      .md_busy_o  (md_busy),
      .sb_busy_o  (sb_busy)
   );

   assign bus.md_busy_o = md_busy;
   assign bus.sb_busy_o = sb_busy;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] lu_cnt_q, sb_cnt_q, fl_cnt_q;
   logic        lu_ev, sb_ev, fl_ev;

   assign lu_ev = !bus.dmem_stall_i && !bus.PCSrc_EX && lu;
   assign sb_ev = !bus.dmem_stall_i && !bus.PCSrc_EX && sbh;
   assign fl_ev = !bus.dmem_stall_i && bus.PCSrc_EX;

   // Saturating event counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lu_cnt_q <= '0;
         sb_cnt_q <= '0;
         fl_cnt_q <= '0;
      end else begin
         if (lu_ev && (lu_cnt_q != '1)) lu_cnt_q <= lu_cnt_q + 32'd1;
         if (sb_ev && (sb_cnt_q != '1)) sb_cnt_q <= sb_cnt_q + 32'd1;
         if (fl_ev && (fl_cnt_q != '1)) fl_cnt_q <= fl_cnt_q + 32'd1;
      end
   end

   assign bus.lu_stall_cnt_o = lu_cnt_q;
   assign bus.sb_stall_cnt_o = sb_cnt_q;
   assign bus.flush_cnt_o    = fl_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// tb_hazard_ctrl_sb: two instances (fixed latency 4, and md_done_i driven)
// share one stimulus stream; outputs are compared against a cycle model.
module tb_hazard_ctrl_sb;
   localparam int unsigned AW  = 5;
   localparam int unsigned LAT = 4;

   typedef struct packed {
      logic [4:0] rs1_ID, rs2_ID, rd_ID;
      logic       use_rs1_ID, use_rs2_ID, wr_ID, md_ID;
      logic [4:0] rs1_EX, rs2_EX, rd_EX;
      logic       load_EX, md_issue_EX, PCSrc_EX;
      logic [4:0] rd_MEM;
      logic       RegWrite_MEM;
      logic [4:0] rd_WB;
      logic       RegWrite_WB;
      logic       dmem_stall_i, md_done_i;
   } in_t;

   typedef struct packed {
      logic       stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX;
      logic [1:0] fa, fb;
   } out_t;

   typedef struct {
      string name;
      in_t   in;
      out_t  exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   in_t         cur;
   out_t        act_ctl[2];
   logic        act_mdb[2];
   logic [31:0] act_sb[2];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit mb[2];
   int mrd[2];
   int iss_cyc[2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      hazard_ctrl_sb_if #(.REG_AW(AW)) bus ();
      hazard_ctrl_sb #(
         .REG_AW       (AW),
         .MD_FIXED_LAT ((g == 0) ? LAT : 0)
      ) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );
      assign bus.rs1_ID       = cur.rs1_ID;
      assign bus.rs2_ID       = cur.rs2_ID;
      assign bus.rd_ID        = cur.rd_ID;
      assign bus.use_rs1_ID   = cur.use_rs1_ID;
      assign bus.use_rs2_ID   = cur.use_rs2_ID;
      assign bus.wr_ID        = cur.wr_ID;
      assign bus.md_ID        = cur.md_ID;
      assign bus.rs1_EX       = cur.rs1_EX;
      assign bus.rs2_EX       = cur.rs2_EX;
      assign bus.rd_EX        = cur.rd_EX;
      assign bus.load_EX      = cur.load_EX;
      assign bus.md_issue_EX  = cur.md_issue_EX;
      assign bus.PCSrc_EX     = cur.PCSrc_EX;
      assign bus.rd_MEM       = cur.rd_MEM;
      assign bus.RegWrite_MEM = cur.RegWrite_MEM;
      assign bus.rd_WB        = cur.rd_WB;
      assign bus.RegWrite_WB  = cur.RegWrite_WB;
      assign bus.dmem_stall_i = cur.dmem_stall_i;
      assign bus.md_done_i    = cur.md_done_i;
      assign act_ctl[g] = {bus.stall_IF, bus.stall_ID, bus.stall_EX, bus.stall_MEM,
                           bus.flush_ID, bus.flush_EX, bus.forwardA_EX, bus.forwardB_EX};
      assign act_mdb[g] = bus.md_busy_o;
      assign act_sb[g]  = bus.sb_busy_o;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
      end
   endtask

   function automatic in_t idle();
      return '0;
   endfunction

   // Model: at most one mul/div outstanding, so the busy vector is one-hot or 0
   function automatic logic [31:0] model_vec(int k);
      return mb[k] ? (32'd1 << mrd[k]) : 32'd0;
   endfunction

   function automatic logic [1:0] fwd(in_t x, logic [4:0] rs);
      if (rs == 0) return 2'b00;
      if (x.RegWrite_MEM && x.rd_MEM == rs) return 2'b10;
      if (x.RegWrite_WB && x.rd_WB == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic out_t exp_comb(in_t x, int k);
      out_t        o;
      logic [31:0] bv;
      logic        lu, sbh;
      bv  = model_vec(k);
      lu  = x.load_EX && (x.rd_EX != 0) &&
            ((x.use_rs1_ID && x.rs1_ID == x.rd_EX) || (x.use_rs2_ID && x.rs2_ID == x.rd_EX));
      sbh = (x.use_rs1_ID && bv[x.rs1_ID]) || (x.use_rs2_ID && bv[x.rs2_ID]) ||
            (x.wr_ID && bv[x.rd_ID]) || (x.md_ID && mb[k]);
      o    = '0;
      o.fa = fwd(x, x.rs1_EX);
      o.fb = fwd(x, x.rs2_EX);
      if (x.dmem_stall_i) begin
         o.stall_IF = 1; o.stall_ID = 1; o.stall_EX = 1; o.stall_MEM = 1;
      end else if (x.PCSrc_EX) begin
         o.flush_ID = 1; o.flush_EX = 1;
      end else if (lu || sbh) begin
         o.stall_IF = 1; o.stall_ID = 1; o.flush_EX = 1;
      end
      return o;
   endfunction

   // Fixed-latency op is busy for cycles iss_cyc .. iss_cyc+LAT-1
   function automatic logic model_done(int k, in_t x);
      if (!mb[k]) return 1'b0;
      if (k == 1) return x.md_done_i;
      return cyc == iss_cyc[k] + int'(LAT) - 1;
   endfunction

   task automatic apply(input in_t x);
      cur = x;
      #2;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("ctl[lat%0d]", (k == 0) ? LAT : 0), act_ctl[k], exp_comb(x, k));
         chk($sformatf("md_busy[lat%0d]", (k == 0) ? LAT : 0), act_mdb[k], mb[k]);
         chk($sformatf("sb_busy[lat%0d]", (k == 0) ? LAT : 0), act_sb[k], model_vec(k));
      end
   endtask

   task automatic tick();
      for (int k = 0; k < 2; k++) begin
         out_t e;
         logic d, acc;
         e   = exp_comb(cur, k);
         d   = model_done(k, cur);
         acc = cur.md_issue_EX && !e.stall_EX && !e.flush_EX && (cur.rd_EX != 0) &&
               (!mb[k] || d);
         if (acc) begin
            mb[k] = 1; mrd[k] = int'(cur.rd_EX); iss_cyc[k] = cyc + 1;
         end else if (d) begin
            mb[k] = 0;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_t x;
      x = idle();
      x.md_done_i = 1;
      for (int j = 0; j < 5; j++) begin
         apply(x);
         tick();
      end
   endtask

   vec_t tbl[12];
   in_t  x;

   initial begin
      mb = '{0, 0};
      mrd = '{0, 0};
      iss_cyc = '{0, 0};
      for (int i = 0; i < 12; i++) tbl[i].in = idle();
      tbl[0].name = "fwd_mem_over_wb";
      tbl[0].in.rs1_EX = 5; tbl[0].in.rd_MEM = 5; tbl[0].in.RegWrite_MEM = 1;
      tbl[0].in.rd_WB = 5; tbl[0].in.RegWrite_WB = 1;
      tbl[0].exp = {6'b000000, 2'b10, 2'b00};
      tbl[1] = tbl[0]; tbl[1].name = "fwd_x0";
      tbl[1].in.rs1_EX = 0; tbl[1].exp = '0;
      tbl[2].name = "fwd_wb_b";
      tbl[2].in.rs2_EX = 4; tbl[2].in.rd_WB = 4; tbl[2].in.RegWrite_WB = 1; tbl[2].in.rd_MEM = 4;
      tbl[2].exp = {6'b000000, 2'b00, 2'b01};
      tbl[3].name = "fwd_mem_both";
      tbl[3].in.rs1_EX = 3; tbl[3].in.rs2_EX = 3; tbl[3].in.rd_MEM = 3;
      tbl[3].in.RegWrite_MEM = 1; tbl[3].in.rd_WB = 3; tbl[3].in.RegWrite_WB = 1;
      tbl[3].exp = {6'b000000, 2'b10, 2'b10};
      tbl[4].name = "fwd_wb_a";
      tbl[4].in.rs1_EX = 2; tbl[4].in.rd_MEM = 6; tbl[4].in.RegWrite_MEM = 1;
      tbl[4].in.rd_WB = 2; tbl[4].in.RegWrite_WB = 1;
      tbl[4].exp = {6'b000000, 2'b01, 2'b00};
      tbl[5].name = "lu_rs2";
      tbl[5].in.load_EX = 1; tbl[5].in.rd_EX = 7; tbl[5].in.rs2_ID = 7; tbl[5].in.use_rs2_ID = 1;
      tbl[5].exp = {6'b110001, 2'b00, 2'b00};
      tbl[6] = tbl[5]; tbl[6].name = "lu_rs2_unused";
      tbl[6].in.use_rs2_ID = 0; tbl[6].exp = '0;
      tbl[7].name = "lu_x0";
      tbl[7].in.load_EX = 1; tbl[7].in.use_rs1_ID = 1;
      tbl[7].exp = '0;
      tbl[8] = tbl[5]; tbl[8].name = "flush_over_lu";
      tbl[8].in.PCSrc_EX = 1; tbl[8].exp = {6'b000011, 2'b00, 2'b00};
      tbl[9] = tbl[8]; tbl[9].name = "dmem_over_all";
      tbl[9].in.dmem_stall_i = 1; tbl[9].exp = {6'b111100, 2'b00, 2'b00};
      tbl[10].name = "flush_only";
      tbl[10].in.PCSrc_EX = 1; tbl[10].exp = {6'b000011, 2'b00, 2'b00};
      tbl[11].name = "lu_rs1";
      tbl[11].in.load_EX = 1; tbl[11].in.rd_EX = 8; tbl[11].in.rs1_ID = 8;
      tbl[11].in.use_rs1_ID = 1; tbl[11].exp = {6'b110001, 2'b00, 2'b00};

      // Reset state
      rst_n = 1'b0;
      cur = idle();
      #12;
      apply(idle());
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Combinational vectors
      for (int i = 0; i < 12; i++) begin
         apply(tbl[i].in);
         chk({tbl[i].name, "[lat4]"}, act_ctl[0], tbl[i].exp);
         chk({tbl[i].name, "[lat0]"}, act_ctl[1], tbl[i].exp);
         tick();
      end

      // Fixed latency 4: rd 9 pending exactly 4 cycles, dependent stalls then goes
      x = idle(); x.md_issue_EX = 1; x.rd_EX = 9;
      apply(x); tick();
      x = idle(); x.rs1_ID = 9; x.use_rs1_ID = 1;
      for (int j = 0; j < 4; j++) begin
         apply(x);
         chk("lat4_dep_stall", act_ctl[0].stall_IF, 1);
         chk("lat4_busy9", act_sb[0][9], 1);
         tick();
      end
      apply(x);
      chk("lat4_dep_proceeds", act_ctl[0].stall_IF, 0);
      chk("lat4_md_idle", act_mdb[0], 0);
      tick();
      drain();

      // Issue held off by data-memory freeze, captured once it drops
      x = idle(); x.md_issue_EX = 1; x.rd_EX = 6; x.dmem_stall_i = 1;
      for (int j = 0; j < 2; j++) begin
         apply(x);
         chk("dmem_stall_mem", act_ctl[0].stall_MEM, 1);
         chk("dmem_not_captured", act_mdb[0], 0);
         tick();
      end
      x.dmem_stall_i = 0;
      apply(x);
      chk("dmem_drop_pre", act_mdb[0], 0);
      tick();
      apply(idle());
      chk("dmem_drop_captured", act_sb[0], 32'h40);
      tick();
      drain();

      // md_done_i completion after 10 cycles
      x = idle(); x.md_issue_EX = 1; x.rd_EX = 3;
      apply(x); tick();
      for (int j = 0; j < 10; j++) begin
         apply(idle());
         chk("lat0_busy3", act_sb[1][3], 1);
         tick();
      end
      x = idle(); x.md_done_i = 1;
      apply(x); tick();
      apply(idle());
      chk("lat0_clear3", act_sb[1], 0);
      tick();

      // Async reset mid-operation
      x = idle(); x.md_issue_EX = 1; x.rd_EX = 3;
      apply(x); tick();
      apply(idle()); tick();
      apply(idle());
      chk("pre_reset_busy", act_mdb[1], 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_sb4", act_sb[0], 0);
      chk("async_rst_sb0", act_sb[1], 0);
      chk("async_rst_md0", act_mdb[1], 0);
      mb = '{0, 0};
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      apply(idle()); tick();

      // Completion and new issue in the same cycle
      x = idle(); x.md_issue_EX = 1; x.rd_EX = 10;
      apply(x); tick();
      for (int j = 0; j < 3; j++) begin
         apply(idle()); tick();
      end
      x = idle(); x.md_issue_EX = 1; x.rd_EX = 11; x.md_done_i = 1;
      apply(x); tick();
      apply(idle());
      chk("reissue_lat4", act_sb[0], 32'h800);
      chk("reissue_lat0", act_sb[1], 32'h800);
      tick();
      drain();

      // Randomized run against the model
      for (int i = 0; i < 400; i++) begin
         logic ok;
         x = idle();
         x.rs1_ID       = 5'($urandom_range(0, 7));
         x.rs2_ID       = 5'($urandom_range(0, 7));
         x.rd_ID        = 5'($urandom_range(0, 7));
         x.use_rs1_ID   = 1'($urandom_range(0, 1));
         x.use_rs2_ID   = 1'($urandom_range(0, 1));
         x.wr_ID        = 1'($urandom_range(0, 1));
         x.md_ID        = ($urandom_range(0, 3) == 0);
         x.rs1_EX       = 5'($urandom_range(0, 7));
         x.rs2_EX       = 5'($urandom_range(0, 7));
         x.rd_EX        = 5'($urandom_range(0, 7));
         x.load_EX      = ($urandom_range(0, 3) == 0);
         x.PCSrc_EX     = ($urandom_range(0, 7) == 0);
         x.rd_MEM       = 5'($urandom_range(0, 7));
         x.RegWrite_MEM = 1'($urandom_range(0, 1));
         x.rd_WB        = 5'($urandom_range(0, 7));
         x.RegWrite_WB  = 1'($urandom_range(0, 1));
         x.dmem_stall_i = ($urandom_range(0, 7) == 0);
         x.md_done_i    = ($urandom_range(0, 5) == 0);
         ok = (!mb[0] || model_done(0, x)) && (!mb[1] || model_done(1, x));
         x.md_issue_EX  = ok && ($urandom_range(0, 2) == 0);
         apply(x);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_sb.md
Name: hazard_ctrl_sb

Overview:
- Second-generation hazard unit for the 5-stage RV32 pipeline: EX-stage operand forwarding, load-use stall, branch flush, data-memory back-pressure freeze, plus a scoreboard for one outstanding multi-cycle mul/div op.
- Sits beside the pipeline registers; drives per-stage stall/flush and the EX forwarding muxes.
- New versus the current unit: parametrised register space, x0/operand-use qualification, multi-cycle tracking, explicit flush-over-stall priority.

Parameters:
- REG_AW, 5, register address width; NUM_REGS = 2**REG_AW.
- MD_FIXED_LAT, 0, 0 means completion comes from md_done_i; N>0 means an internal counter signals completion N cycles after issue (N ≤ 255).

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- rs1_ID, rs2_ID  in  REG_AW  ID source registers
- rd_ID  in  REG_AW  ID destination register
- use_rs1_ID, use_rs2_ID  in  1  ID instruction actually reads the operand
- wr_ID  in  1  ID instruction writes rd
- md_ID  in  1  ID instruction is mul/div
- rs1_EX, rs2_EX, rd_EX  in  REG_AW  EX registers
- load_EX  in  1  EX instruction is a load
- md_issue_EX  in  1  EX instruction is mul/div
- PCSrc_EX  in  1  taken branch/jump in EX
- rd_MEM  in  REG_AW; RegWrite_MEM  in  1
- rd_WB  in  REG_AW; RegWrite_WB  in  1
- dmem_stall_i  in  1  data memory not ready
- md_done_i  in  1  mul/div result written this cycle (used when MD_FIXED_LAT=0)
- stall_IF, stall_ID, stall_EX, stall_MEM  out  1
- flush_ID, flush_EX  out  1
- forwardA_EX, forwardB_EX  out  2  00 regfile, 01 WB, 10 MEM
- md_busy_o  out  1  mul/div outstanding
- sb_busy_o  out  NUM_REGS  per-register pending-write bits

Behaviour:
- Clock and reset: single clock clk, asynchronous active-low reset rst_n.
- Reset values: sb_busy_o=0, md_busy_o=0, FSM=MD_IDLE, counter=0. All combinational outputs then evaluate to 0 given idle inputs.
- Forwarding (combinational):
  - MEM match (RegWrite_MEM, rd_MEM==rsX_EX, rsX_EX!=0) gives 10.
  - Otherwise WB match gives 01.
  - Otherwise 00.
- Load-use (lu): load_EX && rd_EX!=0 && ((use_rs1_ID && rs1_ID==rd_EX) || (use_rs2_ID && rs2_ID==rd_EX)).
- Scoreboard hazard (sbh):
  - RAW: busy[rs1_ID] && use_rs1_ID, or the same for rs2.
  - WAW: wr_ID && busy[rd_ID].
  - Structural: md_ID && md_busy_o.
  - busy[0] is never set.
- Priority, in order:
  - dmem_stall_i: all four stalls=1, no flush; scoreboard issue is not captured this cycle.
  - PCSrc_EX: flush_ID=flush_EX=1, no stalls, even when lu/sbh are true.
  - lu or sbh: stall_IF=stall_ID=1, flush_EX=1 (bubble), stall_EX=stall_MEM=0.
- FSM MD_IDLE → MD_BUSY:
  - Transition on md_issue_EX && !stall_EX && !flush_EX && rd_EX!=0.
  - On transition: latch md_rd=rd_EX, set busy[rd_EX], load counter=MD_FIXED_LAT.
  - Issue with rd_EX==0 stays in IDLE.
- MD_BUSY → MD_IDLE:
  - MD_FIXED_LAT=0: on md_done_i.
  - Otherwise: when the counter reaches 1. The counter decrements every cycle, including during dmem_stall_i.
  - On completion: clear busy[md_rd]; the ID instruction proceeds the next cycle.
- md_done_i in MD_IDLE: ignored.
- Issue in MD_BUSY: cannot happen legally (structural stall). If asserted, it is ignored and flagged by assertion.
- Same-cycle completion + issue: the clear is applied first, then the set (set wins on equal rd).
- Async reset mid-operation: clears the scoreboard immediately.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined:
  - Adds 32-bit saturating counters lu_stall_cnt_o, sb_stall_cnt_o, flush_cnt_o (outputs), incremented on cycles where the respective condition drives the outputs.
  - All reset to 0.
- When undefined: ports and logic are absent; behaviour otherwise identical.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_e (FWD_RF=00, FWD_WB=01, FWD_MEM=10)
  - md_state_e (MD_IDLE, MD_BUSY)
  - REG_AW default constant
- Sub-module md_scoreboard: FSM, counter, busy vector.
- Top level: forwarding, lu detection, priority logic.

Test Plan:
- rs1_EX=5, rd_MEM=5, RegWrite_MEM=1, rd_WB=5, RegWrite_WB=1 → forwardA_EX=10. Same with rs1_EX=0 → 00.
- load_EX=1, rd_EX=7, rs2_ID=7, use_rs2_ID=1 → stall_IF=stall_ID=flush_EX=1 for one cycle. Same with use_rs2_ID=0 → no stall.
- MD_FIXED_LAT=4, issue rd_EX=9 → md_busy_o and sb_busy_o[9] high for exactly 4 cycles. Dependent rs1_ID=9 stalls 4 cycles, then proceeds.
- lu true and PCSrc_EX=1 same cycle → flush_ID=flush_EX=1, stall_IF=0.
- dmem_stall_i=1 during md_issue_EX → no issue captured; issue captured on the first cycle after dmem_stall_i drops.
- MD_FIXED_LAT=0, issue rd=3; md_done_i after 10 cycles → busy[3] clears. rst_n low mid-busy → sb_busy_o=0 asynchronously.
